jt6295_interp: RTL and testbench

JT6295_INTERP -- requirements
Module: jt6295_interp

---
 rtl/jt6295_interp.sv | 62 ++++++
 tb/tb_jt6295_interp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jt6295_interp.sv
// Linear interpolator between consecutive ADPCM samples. It raises the output rate to
// 2^STEPS_LOG2 points per input sample, walking from the previous sample towards the current one.
module jt6295_interp #(
    parameter int STEPS_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen_in,
    input  logic               cen_out,
    input  logic signed [13:0] sound_in,
    output logic signed [13:0] sound_out,
    output logic               sample
);

    // Strobe semantics: cen_in carries a sound_in sample in the same cycle, with no back-pressure.
    // Each cen_out produces exactly one sound_out update, flagged by sample one cycle later.
    localparam int PW = 15 + STEPS_LOG2;
    localparam logic [STEPS_LOG2-1:0] PHASE_MAX = '1;

    logic signed [13:0]       prev, cur;
    logic [STEPS_LOG2-1:0]    phase;

    logic signed [13:0]       prev_eff, cur_eff;
    logic [STEPS_LOG2-1:0]    phase_eff;
    logic signed [14:0]       delta;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     interp;
    logic signed [13:0]       next_out;

    // A coincident cen_in is applied first, so cen_out sees the freshly captured pair.
    always_comb begin
        prev_eff  = cen_in ? cur      : prev;
        cur_eff   = cen_in ? sound_in : cur;
        phase_eff = cen_in ? '0       : phase;
        delta     = 15'(cur_eff) - 15'(prev_eff);
        prod      = PW'(delta) * $signed(PW'(phase_eff));
        interp    = PW'(prev_eff) + (prod >>> STEPS_LOG2);
        // The result lies between prev and cur, so dropping the upper bits is lossless.
        next_out  = 14'(interp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            cur       <= '0;
            phase     <= '0;
            sound_out <= '0;
            sample    <= 1'b0;
        end else begin
            prev   <= prev_eff;
            cur    <= cur_eff;
            sample <= cen_out;
            if (cen_out) begin
                sound_out <= next_out;
                phase     <= (phase_eff == PHASE_MAX) ? PHASE_MAX : phase_eff + 1'b1;
            end else begin
                phase     <= phase_eff;
            end
        end
    end

endmodule

// File: tb/tb_jt6295_interp.sv
// Self-checking bench for jt6295_interp. A cycle-level arithmetic model is compared against the
// DUT on every cycle, and literal output sequences pin the model.
module tb_jt6295_interp;

    localparam int S      = 2;
    localparam int NSTEPS = 1 << S;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen_in = 1'b0;
    logic               cen_out = 1'b0;
    logic signed [13:0] sound_in = '0;
    logic signed [13:0] sound_out;
    logic               sample;

    jt6295_interp #(.STEPS_LOG2(S)) dut (
        .clk(clk), .rst(rst), .cen_in(cen_in), .cen_out(cen_out),
        .sound_in(sound_in), .sound_out(sound_out), .sample(sample)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model state
    int                 m_prev = 0, m_cur = 0, m_phase = 0;
    logic signed [13:0] exp_out = '0;
    logic               exp_sample = 1'b0;
    bit                 check_en = 1'b1;

    int tests = 0;
    int fails = 0;

    logic signed [13:0] exp_q[$];
    logic signed [13:0] got_q[$];

    // Floor of (prev + (cur-prev)*phase/NSTEPS), straight from the arithmetic definition.
    function automatic int interp_point(int p, int c, int ph);
        int num, q;
        num = (c - p) * ph;
        q   = num / NSTEPS;
        if ((num % NSTEPS != 0) && (num < 0)) q = q - 1;
        return p + q;
    endfunction

    // driver: apply one cycle of inputs and advance the model to the post-edge state
    task automatic step(input logic r, input logic ci, input logic co, input logic signed [13:0] si);
        @(negedge clk);
        rst = r; cen_in = ci; cen_out = co; sound_in = si;
        if (r) begin
            m_prev = 0; m_cur = 0; m_phase = 0;
            exp_out = '0; exp_sample = 1'b0;
        end else begin
            if (ci) begin
                m_prev = m_cur; m_cur = int'(si); m_phase = 0;
            end
            exp_sample = co;
            if (co) begin
                exp_out = 14'(interp_point(m_prev, m_cur, m_phase));
                if (m_phase < NSTEPS - 1) m_phase = m_phase + 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic signed [13:0] v);
        step(1'b0, 1'b1, 1'b0, v);
        idle(1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            idle(2);
        end
    endtask

    // scoreboard: compare the sample-pulse outputs collected against exp_q
    task automatic check_seq(input string name);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s: got %0d outputs, expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL %s[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // per-cycle compare process
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            tests++;
            if (sound_out !== exp_out) begin
                fails++;
                $display("FAIL sound_out @%0t: got %0d expected %0d", $time, sound_out, exp_out);
            end
            tests++;
            if (sample !== exp_sample) begin
                fails++;
                $display("FAIL sample @%0t: got %b expected %b", $time, sample, exp_sample);
            end
            if (sample === 1'b1) got_q.push_back(sound_out);
        end
    end

    initial begin
        step(1'b1, 1'b1, 1'b1, 14'sd777);   // reset overrides strobes
        step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        got_q.delete();

        // ramp
        load(0); load(400); pulses(4);
        exp_q = '{14'sd0, 14'sd100, 14'sd200, 14'sd300};
        check_seq("ramp");

        // constant input
        load(1234); pulses(4);
        load(1234); pulses(4);
        load(1234); pulses(4);
        got_q = got_q[4:$];
        exp_q = '{8{14'sd1234}};
        check_seq("constant");

        // negative step
        load(1000); load(-1000); pulses(4);
        exp_q = '{14'sd1000, 14'sd500, 14'sd0, -14'sd500};
        check_seq("neg_step");

        // extremes
        load(-8192); load(8191); pulses(4);
        exp_q = '{-14'sd8192, -14'sd4097, -14'sd1, 14'sd4095};
        check_seq("extremes");

        // coincident cen_in/cen_out, then phase must be 1
        load(300);
        step(1'b0, 1'b1, 1'b1, 14'sd700);
        idle(2);
        pulses(1);
        exp_q = '{14'sd300, 14'sd400};
        check_seq("coincide");

        // excess pulses saturate phase
        load(0); load(400); pulses(6);
        exp_q = '{14'sd0, 14'sd100, 14'sd200, 14'sd300, 14'sd300, 14'sd300};
        check_seq("saturate");

        // reset mid-interpolation
        load(0); load(400); pulses(2);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, '0);
        idle(1);
        pulses(1);
        exp_q = '{14'sd0, 14'sd100, 14'sd0};
        check_seq("mid_reset");

        // history shift without output
        load(-50); load(50); load(250); pulses(1);
        exp_q = '{14'sd50};
        check_seq("no_output_shift");

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0),
                 14'($urandom_range(0, 16383)));
        end
        idle(2);
        got_q.delete();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
